// File: rtl/sprite_line_scanner.sv
// OAM scan stage: walks the sprite attribute table once per scanline and keeps,
// in OAM order, the first MAX_PER_LINE sprites whose rows cover the line.
module sprite_line_scanner #(
    parameter int NUM_SPRITES  = 40,
    parameter int MAX_PER_LINE = 10,
    parameter int Y_OFFSET     = 16,
    parameter int IDX_BITS     = $clog2(NUM_SPRITES),
    parameter int CNT_BITS     = $clog2(MAX_PER_LINE + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          line,
    input  logic                tall_mode,
    input  logic                sprite_enable,
    output logic                oam_rd_en,
    output logic [IDX_BITS-1:0] oam_addr,
    input  logic [7:0]          oam_y,
    input  logic [7:0]          oam_x,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] count,
    output logic                overflow,
    input  logic [CNT_BITS-1:0] sel_idx,
    output logic                sel_valid,
    output logic [IDX_BITS-1:0] sel_oam,
    output logic [7:0]          sel_x,
    output logic [3:0]          sel_row
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [IDX_BITS-1:0] LAST_ADDR = IDX_BITS'(NUM_SPRITES - 1);
    localparam logic [CNT_BITS-1:0] MAX_CNT   = CNT_BITS'(MAX_PER_LINE);
    localparam logic [9:0]          Y_OFF10   = 10'(Y_OFFSET);

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] addr_q, addr_d;
    logic [7:0]          line_q, line_d;
    logic                tall_q, tall_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                pend_q, pend_d;
    logic [IDX_BITS-1:0] pend_idx_q, pend_idx_d;

    logic [9:0] diff;
    logic       hit;
    logic       store;

    logic [IDX_BITS-1:0] slot_oam [MAX_PER_LINE];
    logic [7:0]          slot_x   [MAX_PER_LINE];
    logic [3:0]          slot_row [MAX_PER_LINE];

    // 10-bit arithmetic so sprites above the top of the screen never wrap into a hit.
    always_comb begin
        diff  = {2'b00, line_q} + Y_OFF10 - {2'b00, oam_y};
        hit   = pend_q && !diff[9] && (diff < (tall_q ? 10'd16 : 10'd8));
        store = hit && (count_q < MAX_CNT);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        tall_d     = tall_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pend_d     = (state_q == SCAN);
        pend_idx_d = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    if (sprite_enable) begin
                        line_d  = line;
                        tall_d  = tall_mode;
                        addr_d  = '0;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + IDX_BITS'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (store) begin
            count_d = count_q + CNT_BITS'(1);
        end
        if (hit && !store) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            line_q     <= '0;
            tall_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            tall_q     <= tall_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_PER_LINE; gi++) begin : g_slot
            logic [IDX_BITS-1:0] oam_q, oam_d;
            logic [7:0]          x_q, x_d;
            logic [3:0]          row_q, row_d;

            always_comb begin
                oam_d = oam_q;
                x_d   = x_q;
                row_d = row_q;
                if (store && (count_q == CNT_BITS'(gi))) begin
                    oam_d = pend_idx_q;
                    x_d   = oam_x;
                    row_d = diff[3:0];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    oam_q <= '0;
                    x_q   <= '0;
                    row_q <= '0;
                end else begin
                    oam_q <= oam_d;
                    x_q   <= x_d;
                    row_q <= row_d;
                end
            end

            assign slot_oam[gi] = oam_q;
            assign slot_x[gi]   = x_q;
            assign slot_row[gi] = row_q;
        end
    endgenerate

    always_comb begin
        sel_valid = (sel_idx < count_q);
        sel_oam   = '0;
        sel_x     = '0;
        sel_row   = '0;
        if (sel_valid) begin
            sel_oam = slot_oam[sel_idx];
            sel_x   = slot_x[sel_idx];
            sel_row = slot_row[sel_idx];
        end
    end

    assign oam_rd_en = (state_q == SCAN);
    assign oam_addr  = addr_q;
    assign busy      = (state_q == SCAN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Bench for sprite_line_scanner: OAM memory model, reference selection model
// and a scoreboard queue of expected per-line results.
module tb_sprite_line_scanner;
    localparam int N  = 40;
    localparam int M  = 10;
    localparam int IW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [7:0]    line;
    logic          tall_mode;
    logic          sprite_enable;
    logic          oam_rd_en;
    logic [IW-1:0] oam_addr;
    logic [7:0]    oam_y = 8'd0;
    logic [7:0]    oam_x = 8'd0;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;
    logic [CW-1:0] sel_idx;
    logic          sel_valid;
    logic [IW-1:0] sel_oam;
    logic [7:0]    sel_x;
    logic [3:0]    sel_row;

    logic [7:0] mem_y [N];
    logic [7:0] mem_x [N];

    typedef struct {
        int cnt;
        int ov;
        int oam [M];
        int x   [M];
        int row [M];
    } exp_t;

    exp_t sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    sprite_line_scanner #(
        .NUM_SPRITES (N),
        .MAX_PER_LINE(M),
        .Y_OFFSET    (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .line         (line),
        .tall_mode    (tall_mode),
        .sprite_enable(sprite_enable),
        .oam_rd_en    (oam_rd_en),
        .oam_addr     (oam_addr),
        .oam_y        (oam_y),
        .oam_x        (oam_x),
        .busy         (busy),
        .done         (done),
        .count        (count),
        .overflow     (overflow),
        .sel_idx      (sel_idx),
        .sel_valid    (sel_valid),
        .sel_oam      (sel_oam),
        .sel_x        (sel_x),
        .sel_row      (sel_row)
    );

    always #5 clk = ~clk;

    // OAM with one cycle of read latency.
    always @(posedge clk) begin
        if (oam_rd_en) begin
            oam_y <= mem_y[oam_addr];
            oam_x <= mem_x[oam_addr];
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int ln, input int tm, input int en);
        exp_t e;
        int d;
        int h;
        e.cnt = 0;
        e.ov  = 0;
        for (int i = 0; i < M; i++) begin
            e.oam[i] = 0;
            e.x[i]   = 0;
            e.row[i] = 0;
        end
        if (en != 0) begin
            h = (tm != 0) ? 16 : 8;
            for (int i = 0; i < N; i++) begin
                d = ln + 16 - int'(mem_y[i]);
                if (d >= 0 && d < h) begin
                    if (e.cnt < M) begin
                        e.oam[e.cnt] = i;
                        e.x[e.cnt]   = int'(mem_x[i]);
                        e.row[e.cnt] = d;
                        e.cnt++;
                    end else begin
                        e.ov = 1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < N; i++) begin
            mem_y[i] = 8'd0;
            mem_x[i] = 8'd0;
        end
    endtask

    task automatic run_scan(input logic [7:0] ln, input logic tm, input logic en, input bit poke);
        exp_t e;
        int   lat;
        int   rd;
        int   busy_err;
        int   extra;
        bit   got;
        sb.push_back(model(int'(ln), int'(tm), int'(en)));
        @(negedge clk);
        line = ln;
        tall_mode = tm;
        sprite_enable = en;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        line = ~ln;
        tall_mode = ~tm;
        rd = 0;
        busy_err = 0;
        got = 1'b0;
        lat = -1;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            start = poke && (j == 10);
            if (oam_rd_en) begin
                check_val("rd_addr", int'(oam_addr), rd);
                rd++;
            end
            if (done) begin
                got = 1'b1;
                lat = j;
                check_val("busy_in_done", int'(busy), 0);
                break;
            end
            if (!busy) busy_err++;
        end
        start = 1'b0;
        check_val("done_seen", int'(got), 1);
        check_val("latency", lat, en ? N + 1 : 0);
        check_val("rd_cycles", rd, en ? N : 0);
        check_val("busy_gap", busy_err, 0);
        e = sb.pop_front();
        check_val("count", int'(count), e.cnt);
        check_val("overflow", int'(overflow), e.ov);
        for (int i = 0; i <= M; i++) begin
            sel_idx = CW'(i);
            #1;
            check_val("sel_valid", int'(sel_valid), (i < e.cnt) ? 1 : 0);
            if (i < M) begin
                check_val("sel_oam", int'(sel_oam), e.oam[i]);
                check_val("sel_x", int'(sel_x), e.x[i]);
                check_val("sel_row", int'(sel_row), e.row[i]);
            end else begin
                check_val("sel_oam_oob", int'(sel_oam), 0);
                check_val("sel_x_oob", int'(sel_x), 0);
                check_val("sel_row_oob", int'(sel_row), 0);
            end
        end
        extra = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_val("extra_done", extra, 0);
        $display("scan line=%0d tall=%0d en=%0d poke=%0d latency=%0d count=%0d overflow=%0d",
                 ln, tm, en, poke, lat, count, overflow);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   found;
        int   dones;
        logic [7:0] rl;
        reset_n = 1'b0;
        start = 1'b0;
        line = 8'd0;
        tall_mode = 1'b0;
        sprite_enable = 1'b1;
        sel_idx = '0;
        clear_oam();

        repeat (3) @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_rd_en", int'(oam_rd_en), 0);
        check_val("rst_addr", int'(oam_addr), 0);
        check_val("rst_count", int'(count), 0);
        check_val("rst_overflow", int'(overflow), 0);
        check_val("rst_sel_valid", int'(sel_valid), 0);
        reset_n = 1'b1;
        $display("reset released");

        // All Y=0: nothing on line 5.
        run_scan(8'd5, 1'b0, 1'b1, 1'b0);
        check_val("plan_empty_cnt", int'(count), 0);

        // Three sprites at Y=20.
        mem_y[3] = 8'd20;  mem_x[3] = 8'd8;
        mem_y[7] = 8'd20;  mem_x[7] = 8'd50;
        mem_y[20] = 8'd20; mem_x[20] = 8'd100;
        run_scan(8'd6, 1'b0, 1'b1, 1'b0);
        check_val("plan_three_cnt", int'(count), 3);
        run_scan(8'd13, 1'b0, 1'b1, 1'b0);
        check_val("plan_short_cnt", int'(count), 0);
        run_scan(8'd13, 1'b1, 1'b1, 1'b0);
        check_val("plan_tall_cnt", int'(count), 3);
        sel_idx = CW'(1);
        #1;
        check_val("plan_tall_row", int'(sel_row), 9);

        // Twelve sprites on line 0: overflow, and Y=0 entries must not wrap into hits.
        clear_oam();
        for (int i = 0; i < 12; i++) begin
            mem_y[i] = 8'd16;
            mem_x[i] = 8'(10 + i);
        end
        mem_x[5] = 8'd0;
        mem_x[6] = 8'd200;
        run_scan(8'd0, 1'b0, 1'b1, 1'b0);
        check_val("plan_ovf_cnt", int'(count), 10);
        check_val("plan_ovf_flag", int'(overflow), 1);
        sel_idx = CW'(9);
        #1;
        check_val("plan_last_oam", int'(sel_oam), 9);
        run_scan(8'd0, 1'b1, 1'b1, 1'b0);

        // Sprites disabled: immediate done with empty results.
        run_scan(8'd0, 1'b0, 1'b0, 1'b0);
        check_val("plan_disabled_cnt", int'(count), 0);
        check_val("plan_disabled_ovf", int'(overflow), 0);

        // Extra start while busy is ignored.
        clear_oam();
        mem_y[3] = 8'd20;  mem_x[3] = 8'd8;
        mem_y[7] = 8'd20;  mem_x[7] = 8'd50;
        mem_y[20] = 8'd20; mem_x[20] = 8'd100;
        run_scan(8'd6, 1'b0, 1'b1, 1'b1);

        // Reset mid-scan at address 15.
        @(negedge clk);
        line = 8'd6;
        tall_mode = 1'b0;
        sprite_enable = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (oam_rd_en && oam_addr == IW'(15)) begin
                found = 1;
                break;
            end
        end
        check_val("abort_reach", found, 1);
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_count", int'(count), 0);
        check_val("abort_rd_en", int'(oam_rd_en), 0);
        check_val("abort_done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("abort_no_done", dones, 0);
        $display("abort at addr 15 done_pulses=%0d", dones);
        run_scan(8'd6, 1'b0, 1'b1, 1'b0);
        check_val("plan_after_abort_cnt", int'(count), 3);

        // Randomised OAM clustered around the line.
        for (int r = 0; r < 4; r++) begin
            rl = 8'($urandom_range(0, 143));
            for (int i = 0; i < N; i++) begin
                mem_y[i] = 8'(int'(rl) + 16 - int'($urandom_range(0, 40)));
                mem_x[i] = 8'($urandom_range(0, 255));
            end
            run_scan(rl, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_line_scanner.md
Name: sprite_line_scanner

Overview:
- Parametrised OAM scan stage for the graphics subsystem.
- On each scanline start it walks the sprite attribute table one entry per clock and selects, in OAM order, up to MAX_PER_LINE sprites that intersect the line.
- Supports 8- or 16-pixel-tall sprites and flags overflow.
- Its selection list feeds the pixel/sprite renderer, replacing the renderer's per-line loop over all sprites.

Parameters:
- NUM_SPRITES, 40: OAM entries scanned per line (>=1).
- MAX_PER_LINE, 10: selection buffer depth (1..NUM_SPRITES).
- Y_OFFSET, 16: value added to the line before the OAM Y comparison.
- IDX_BITS, $clog2(NUM_SPRITES): width of OAM index.
- CNT_BITS, $clog2(MAX_PER_LINE+1): width of selection count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request scan of line; sampled only in IDLE.
- line  in  8  current LCD line.
- tall_mode  in  1  0 = 8-row sprites, 1 = 16-row sprites.
- sprite_enable  in  1  0 = no sprites selected.
- oam_rd_en  out  1  OAM read strobe.
- oam_addr  out  IDX_BITS  OAM entry index being read.
- oam_y  in  8  Y byte of entry; valid the cycle after oam_rd_en.
- oam_x  in  8  X byte of entry; same timing as oam_y.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when results are valid.
- count  out  CNT_BITS  number of selected sprites.
- overflow  out  1  more than MAX_PER_LINE sprites hit the line.
- sel_idx  in  CNT_BITS  selection list read index.
- sel_valid  out  1  sel_idx < count.
- sel_oam  out  IDX_BITS  OAM index of selected entry.
- sel_x  out  8  X byte of selected entry.
- sel_row  out  4  row within sprite (0..7 or 0..15), before any Y-flip.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, oam_rd_en=0, oam_addr=0, busy=0, done=0, count=0, overflow=0, all buffer entries cleared. Reset mid-scan aborts the scan, and no done pulse is produced.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE, start=1 and sprite_enable=1: latch line and tall_mode, clear count and overflow, go to SCAN with oam_addr=0 and oam_rd_en=1.
- IDLE, start=1 and sprite_enable=0: clear count and overflow, go directly to DONE.
- SCAN: oam_rd_en=1. oam_addr increments each cycle. When an edge is taken with oam_addr=NUM_SPRITES-1, go to DRAIN with oam_rd_en=0.
- DRAIN: evaluate the last returned entry, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Evaluation of the entry returned in each cycle after a read:
  - d = line + Y_OFFSET - oam_y, computed in 10-bit signed.
  - h = 16 if the latched tall_mode is 1, else 8.
  - hit when 0 <= d < h.
  - On hit with count < MAX_PER_LINE: store {oam index, oam_x, d[3:0]} at slot count, and count increments.
  - On hit with count == MAX_PER_LINE: overflow=1; buffer and count unchanged.
- X is not filtered: entries with off-screen X (0, >=168) still occupy a slot.
- Latency: done is high in the cycle following edge NUM_SPRITES+1, counting the start-sampling edge as edge 0 (NUM_SPRITES+2 cycles total). The sprite_enable=0 path takes 1 cycle.
- busy=1 in SCAN and DRAIN; 0 in IDLE and DONE.
- start in any state other than IDLE is ignored (not queued).
- Changes to line or tall_mode during a scan have no effect.
- count, overflow and the buffer hold their values from done until the next accepted start.
- Selection read port is combinational from sel_idx. When sel_idx >= count: sel_valid=0, and sel_oam/sel_x/sel_row read 0.
- Reading the selection port during a scan returns partial results; defined but not guaranteed useful.
- Y arithmetic must not wrap at 8 bits. Example: line=0, oam_y=0 gives d=16, which is no hit in either mode.

Test Plan:
- All 40 entries have Y=0; start with line=5 -> oam_rd_en high 40 cycles, addr 0..39. Done pulses exactly 42 cycles after start; count=0, overflow=0.
- Entries 3, 7, 20 have Y=20, X=8,50,100; line=6, tall_mode=0 -> count=3; sel_idx 0..2 give oam 3/7/20, x 8/50/100, row 2; sel_idx 3 gives sel_valid=0 and zero outputs.
- Same OAM with line=13: tall_mode=0 -> count=0 (d=9); tall_mode=1 -> count=3, sel_row=9.
- 12 entries (indices 0..11) all Y=16, line=0 -> count=10, overflow=1, last stored oam index 9.
- sprite_enable=0 with a start pulse -> done next cycle, count=0, no oam_rd_en. Then start asserted during a busy scan is ignored, and only one done pulse is seen.
- reset_n dropped at addr 15 mid-scan -> immediately busy=0, count=0, oam_rd_en=0, no done pulse. A new start then completes normally with correct results.
